// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the ID-stage register file and its busy scoreboard.
package regfile_pkg;

   localparam int NREAD_MAX = 4;
   localparam int REG_ZERO  = 0;

   // Elaboration-time ceil(log2(depth)); depth is expected to be a power of two >= 2.
   function automatic int calc_aw(input int depth);
      int aw;
      aw = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < depth) aw = i + 1;
      end
      return aw;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for pending writebacks, plus a registered count of busy registers.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int AW    = calc_aw(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_regn,
   input  logic             mark_en,
   input  logic [AW-1:0]    mark_regn,
   output logic [DEPTH-1:0] busy,
   output logic [AW:0]      pend_cnt
);

   logic [DEPTH-1:0] busy_d;
   logic [DEPTH-1:0] busy_q;
   logic [AW:0]      pend_cnt_d;
   logic [AW:0]      pend_cnt_q;

   always_comb begin
      busy_d = busy_q;
      if (clr_en && (clr_regn != AW'(REG_ZERO))) busy_d[clr_regn] = 1'b0;
      // Mark is applied last: a writeback landing on the same edge a new one is issued
      // must not hide the newer pending result.
      if (mark_en && (mark_regn != AW'(REG_ZERO))) busy_d[mark_regn] = 1'b1;
      busy_d[REG_ZERO] = 1'b0;
   end

   always_comb begin
      pend_cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         pend_cnt_d = pend_cnt_d + (AW+1)'(busy_d[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         busy_q     <= busy_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign busy     = busy_q;
   assign pend_cnt = pend_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// MIPS register file: NREAD combinational read ports, one write port, optional write-to-read
// bypass, and a busy scoreboard feeding the hazard/stall unit.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int NREAD  = 2,
   parameter int BYPASS = 1,
   localparam int AW    = calc_aw(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREAD*AW-1:0]    rd_addr,
   output logic [NREAD*WIDTH-1:0] rd_data,
   output logic [NREAD-1:0]       rd_busy,
   input  logic                   wen,
   input  logic [AW-1:0]          wregn,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   mark_en,
   input  logic [AW-1:0]          mark_regn,
   output logic [AW:0]            pend_cnt
);

   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_vld;
   logic [DEPTH-1:0] busy;

   assign wr_vld = wen && (wregn != AW'(REG_ZERO));

   always_comb begin
      mem_d = mem_q;
      if (wr_vld) mem_d[wregn] = wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   regfile_scoreboard #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .clr_en    (wen),
      .clr_regn  (wregn),
      .mark_en   (mark_en),
      .mark_regn (mark_regn),
      .busy      (busy),
      .pend_cnt  (pend_cnt)
   );

   for (genvar p = 0; p < NREAD; p++) begin : g_rd
      logic [AW-1:0]    addr;
      logic             fwd;
      logic [WIDTH-1:0] rd_val;

      assign addr = rd_addr[p*AW +: AW];
      // A writeback arriving this cycle resolves the operand, so it is neither stale nor busy.
      assign fwd  = (BYPASS != 0) && wen && (wregn == addr);

      assign rd_val = (addr == AW'(REG_ZERO)) ? '0    :
                      fwd                     ? wdata :
                                                mem_q[addr];

      assign rd_data[p*WIDTH +: WIDTH] = rd_val;
      assign rd_busy[p]                = busy[addr] & ~fwd;
   end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data_a, rd_data_b;
   logic [1:0]  rd_busy_a, rd_busy_b;
   logic        wen;
   logic [4:0]  wregn;
   logic [31:0] wdata;
   logic        mark_en;
   logic [4:0]  mark_regn;
   logic [5:0]  pend_a, pend_b;

   logic [15:0] rd_addr_c;
   logic [63:0] rd_data_c;
   logic [3:0]  rd_busy_c;
   logic        wen_c;
   logic [3:0]  wregn_c;
   logic [15:0] wdata_c;
   logic        mark_en_c;
   logic [3:0]  mark_regn_c;
   logic [4:0]  pend_c;

   regfile_sb #(.WIDTH(32), .DEPTH(32), .NREAD(2), .BYPASS(1)) dut_a (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
      .wen(wen), .wregn(wregn), .wdata(wdata), .mark_en(mark_en), .mark_regn(mark_regn),
      .pend_cnt(pend_a));

   regfile_sb #(.WIDTH(32), .DEPTH(32), .NREAD(2), .BYPASS(0)) dut_b (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wen(wen), .wregn(wregn), .wdata(wdata), .mark_en(mark_en), .mark_regn(mark_regn),
      .pend_cnt(pend_b));

   regfile_sb #(.WIDTH(16), .DEPTH(16), .NREAD(4), .BYPASS(1)) dut_c (
      .clk(clk), .reset(reset), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
      .wen(wen_c), .wregn(wregn_c), .wdata(wdata_c), .mark_en(mark_en_c),
      .mark_regn(mark_regn_c), .pend_cnt(pend_c));

   typedef enum int {K_DATA, K_BUSY, K_PEND} kind_e;
   typedef struct {
      int          dut;
      kind_e       kind;
      int          port;
      logic [31:0] val;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [31:0] actual_of(int dut, kind_e kind, int port);
      logic [31:0] r;
      r = 32'hxxxx_xxxx;
      case (dut)
         0: case (kind)
               K_DATA:  r = rd_data_a[port*32 +: 32];
               K_BUSY:  r = 32'(rd_busy_a[port]);
               default: r = 32'(pend_a);
            endcase
         1: case (kind)
               K_DATA:  r = rd_data_b[port*32 +: 32];
               K_BUSY:  r = 32'(rd_busy_b[port]);
               default: r = 32'(pend_b);
            endcase
         default: case (kind)
               K_DATA:  r = 32'(rd_data_c[port*16 +: 16]);
               K_BUSY:  r = 32'(rd_busy_c[port]);
               default: r = 32'(pend_c);
            endcase
      endcase
      return r;
   endfunction

   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (sb_q.size() != 0) begin
         e   = sb_q.pop_front();
         act = actual_of(e.dut, e.kind, e.port);
         n_checks++;
         if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s dut%0d port%0d: got %0h expected %0h", e.tag, e.dut, e.port, act, e.val);
         end
      end
   end

   task automatic push(int dut, kind_e k, int port, logic [31:0] v, string tag);
      exp_t e;
      e.dut = dut; e.kind = k; e.port = port; e.val = v; e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic exp_ab(int port, logic [31:0] da, logic [31:0] db, logic ba, logic bb, string tag);
      push(0, K_DATA, port, da, tag);
      push(1, K_DATA, port, db, tag);
      push(0, K_BUSY, port, 32'(ba), tag);
      push(1, K_BUSY, port, 32'(bb), tag);
   endtask

   task automatic exp_pend(int v, string tag);
      push(0, K_PEND, 0, 32'(v), tag);
      push(1, K_PEND, 0, 32'(v), tag);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(int a0, int a1);
      rd_addr = {5'(a1), 5'(a0)};
   endtask

   logic [15:0] mem_m [16];
   logic [15:0] busy_m;

   task automatic c_clear();
      for (int i = 0; i < 16; i++) mem_m[i] = '0;
      busy_m = '0;
   endtask

   task automatic c_edge();
      if (reset) begin
         c_clear();
      end else begin
         if (wen_c && wregn_c != 4'd0) begin
            mem_m[wregn_c]  = wdata_c;
            busy_m[wregn_c] = 1'b0;
         end
         if (mark_en_c && mark_regn_c != 4'd0) busy_m[mark_regn_c] = 1'b1;
      end
   endtask

   task automatic c_cycle(logic w, int wr, logic [15:0] wd, logic m, int mr,
                          int a0, int a1, int a2, int a3, logic do_reset, string tag);
      int          a [4];
      logic        hit;
      logic [15:0] d;
      @(posedge clk);
      c_edge();
      #1;
      reset       = 1'b0;
      wen_c       = w;
      wregn_c     = 4'(wr);
      wdata_c     = wd;
      mark_en_c   = m;
      mark_regn_c = 4'(mr);
      rd_addr_c   = {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
      if (do_reset) begin
         #2;
         reset = 1'b1;
         c_clear();
      end
      a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
      for (int p = 0; p < 4; p++) begin
         hit = !reset && w && (wr == a[p]);
         d   = (a[p] == 0) ? 16'h0 : (hit ? wd : mem_m[a[p]]);
         push(2, K_DATA, p, 32'(d), tag);
         push(2, K_BUSY, p, 32'(busy_m[a[p]] && !hit), tag);
      end
      push(2, K_PEND, 0, 32'($countones(busy_m)), tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      rd_addr = '0; wen = 0; wregn = '0; wdata = '0; mark_en = 0; mark_regn = '0;
      rd_addr_c = '0; wen_c = 0; wregn_c = '0; wdata_c = '0; mark_en_c = 0; mark_regn_c = '0;
      c_clear();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      n_checks++;
      if (pend_a !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_direct_pend_a: got %0h expected 0", pend_a);
      end
      n_checks++;
      if (pend_b !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_direct_pend_b: got %0h expected 0", pend_b);
      end
      n_checks++;
      if (rd_busy_a !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_direct_busy_a: got %0h expected 0", rd_busy_a);
      end
      n_checks++;
      if (rd_busy_b !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_direct_busy_b: got %0h expected 0", rd_busy_b);
      end
      n_checks++;
      if (pend_c !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_direct_pend_c: got %0h expected 0", pend_c);
      end

      for (int i = 0; i < 32; i++) begin
         step();
         set_rd(i, 31 - i);
         exp_ab(0, 0, 0, 0, 0, "reset_rd");
         exp_ab(1, 0, 0, 0, 0, "reset_rd");
         exp_pend(0, "reset_pend");
      end

      for (int i = 1; i < 32; i++) begin
         step();
         wen = 1; wregn = 5'(i); wdata = 32'(i);
      end
      step();
      wen = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         set_rd(i, (i + 1) % 32);
         exp_ab(0, i, i, 0, 0, "wr_rd");
         exp_ab(1, (i + 1) % 32, (i + 1) % 32, 0, 0, "wr_rd");
      end
      step();
      wen = 1; wregn = 0; wdata = 32'hFFFF; set_rd(0, 0);
      exp_ab(0, 0, 0, 0, 0, "r0_wr_bypass");
      step();
      wen = 0;
      exp_ab(0, 0, 0, 0, 0, "r0_after_wr");
      exp_ab(1, 0, 0, 0, 0, "r0_after_wr");

      step();
      wen = 1; wregn = 5; wdata = 32'hDEAD; set_rd(5, 6);
      exp_ab(0, 32'hDEAD, 5, 0, 0, "bypass_same_cycle");
      exp_ab(1, 6, 6, 0, 0, "bypass_other_port");
      step();
      wen = 0;
      exp_ab(0, 32'hDEAD, 32'hDEAD, 0, 0, "after_wr5");

      step(); mark_en = 1; mark_regn = 7; exp_pend(0, "mark7_pend");
      step(); mark_regn = 9;              exp_pend(1, "mark9_pend");
      step(); mark_regn = 7;              exp_pend(2, "mark7_again_pend");
      step(); mark_en = 0; set_rd(7, 9);
      exp_pend(2, "no_double_count");
      exp_ab(0, 7, 7, 1, 1, "busy7");
      exp_ab(1, 9, 9, 1, 1, "busy9");
      step();
      wen = 1; wregn = 9; wdata = 32'h99;
      exp_ab(1, 32'h99, 9, 0, 1, "wb9_same_cycle");
      exp_ab(0, 7, 7, 1, 1, "busy7_during_wb9");
      exp_pend(2, "pend_during_wb9");
      step();
      wen = 0;
      exp_ab(1, 32'h99, 32'h99, 0, 0, "after_wb9");
      exp_pend(1, "pend_after_wb9");

      step();
      mark_en = 1; mark_regn = 12; wen = 1; wregn = 12; wdata = 32'h55; set_rd(12, 7);
      exp_ab(0, 32'h55, 12, 0, 0, "mark_wr12_same_cycle");
      exp_pend(1, "pend_before_mark12");
      step();
      mark_en = 0; wen = 0;
      exp_ab(0, 32'h55, 32'h55, 1, 1, "mark_wins12");
      exp_pend(2, "pend_mark12");
      step();
      mark_en = 1; mark_regn = 0; set_rd(0, 12);
      exp_ab(0, 0, 0, 0, 0, "r0_mark");
      step();
      mark_en = 0; wen = 1; wregn = 20; wdata = 32'h2020;
      exp_ab(0, 0, 0, 0, 0, "r0_never_busy");
      exp_pend(2, "mark0_ignored");
      step();
      wen = 0; set_rd(20, 12);
      exp_ab(0, 32'h2020, 32'h2020, 0, 0, "wr_nonbusy20");
      exp_pend(2, "wr_nonbusy_pend");

      step(); mark_en = 1; mark_regn = 3; exp_pend(2, "pre_mark3");
      step(); mark_regn = 4;              exp_pend(3, "mark3_pend");
      step(); mark_en = 0; set_rd(3, 4);
      exp_ab(0, 3, 3, 1, 1, "busy3");
      exp_ab(1, 4, 4, 1, 1, "busy4");
      exp_pend(4, "mark4_pend");
      step();
      mark_en = 1; mark_regn = 5;
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (pend_a !== 6'd0) begin
         n_fail++;
         $display("FAIL async_rst_direct_pend_a: got %0h expected 0", pend_a);
      end
      n_checks++;
      if (pend_b !== 6'd0) begin
         n_fail++;
         $display("FAIL async_rst_direct_pend_b: got %0h expected 0", pend_b);
      end
      exp_ab(0, 0, 0, 0, 0, "async_rst3");
      exp_ab(1, 0, 0, 0, 0, "async_rst4");
      exp_pend(0, "async_rst_pend");
      step();
      mark_en = 0; reset = 1'b0; set_rd(5, 7);
      exp_ab(0, 0, 0, 0, 0, "rst_discards_mark5");
      exp_ab(1, 0, 0, 0, 0, "rst_clears7");
      exp_pend(0, "rst_pend");

      for (int r = 1; r < 16; r++) begin
         c_cycle(1, r, 16'(r * 16'h1111), 0, 0, r, r - 1, 0, 15 - r, 0, "c_wr");
      end
      c_cycle(0, 0, 0, 1, 3, 3, 4, 15, 1, 0, "c_mark3");
      c_cycle(0, 0, 0, 1, 4, 3, 4, 15, 1, 0, "c_mark4");
      c_cycle(1, 4, 16'hABCD, 1, 3, 3, 4, 0, 5, 0, "c_mark3_wb4");
      c_cycle(1, 6, 16'h0606, 1, 6, 6, 4, 3, 5, 0, "c_mark_wr6");
      c_cycle(0, 0, 0, 1, 0, 6, 4, 3, 0, 0, "c_mark0");
      c_cycle(0, 0, 0, 0, 0, 6, 4, 3, 0, 0, "c_idle");
      c_cycle(0, 0, 0, 1, 7, 3, 4, 6, 7, 1, "c_async_rst");
      c_cycle(0, 0, 0, 0, 0, 3, 4, 6, 7, 0, "c_after_rst");
      c_cycle(0, 0, 0, 0, 0, 15, 1, 2, 7, 0, "c_after_rst2");

      step();
      @(negedge clk);
      #1;
      n_checks++;
      if (pend_c !== 5'd0) begin
         n_fail++;
         $display("FAIL end_direct_pend_c: got %0h expected 0", pend_c);
      end
      n_checks++;
      if (pend_a !== 6'd0) begin
         n_fail++;
         $display("FAIL end_direct_pend_a: got %0h expected 0", pend_a);
      end
      n_checks++;
      if (pend_b !== 6'd0) begin
         n_fail++;
         $display("FAIL end_direct_pend_b: got %0h expected 0", pend_b);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
